// File: rtl/philv_load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 opcodes, FSM states, captured request record.
package philv_load_store_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LSU_STATE_WIDTH = 2;

  typedef enum logic [LSU_STATE_WIDTH-1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/philv_load_store_unit_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
interface philv_load_store_unit_if;
  import philv_load_store_unit_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_rd_ena;
  logic            mem_wr_ena;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wr_data;
  logic [3:0]      mem_wr_mask;
  logic [XLEN-1:0] mem_rd_data;
  logic            mem_ack;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_rd_ena, mem_wr_ena, mem_addr, mem_wr_data, mem_wr_mask
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_rd_ena, mem_wr_ena, mem_addr, mem_wr_data, mem_wr_mask
  );

endinterface

// File: rtl/philv_load_store_unit_lane_align.sv
// Combinational lane logic: load extraction/extension, store replication + byte mask,
// and the misaligned / illegal-funct3 flag.
module philv_load_store_unit_lane_align
  import philv_load_store_unit_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] rd_word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] st_data,
  output logic [3:0]      st_mask,
  output logic            err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rd_word[{lane, 3'b000} +: 8];
  assign sel_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    st_data   = '0;
    st_mask   = '0;
    err       = 1'b0;
    if (we) begin
      case (funct3)
        F3_B: begin
          st_mask = 4'b0001 << lane;
          st_data = {4{wdata[7:0]}};
        end
        F3_H: begin
          err     = lane[0];
          st_mask = 4'b0011 << lane;
          st_data = {2{wdata[15:0]}};
        end
        F3_W: begin
          err     = |lane;
          st_mask = 4'hF;
          st_data = wdata;
        end
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:  load_data = {{24{sel_byte[7]}}, sel_byte};
        F3_BU: load_data = {24'd0, sel_byte};
        F3_H: begin
          err       = lane[0];
          load_data = {{16{sel_half[15]}}, sel_half};
        end
        F3_HU: begin
          err       = lane[0];
          load_data = {16'd0, sel_half};
        end
        F3_W: begin
          err       = |lane;
          load_data = rd_word;
        end
        default: err = 1'b1;
      endcase
    end
    // Faulting stores must never present a write mask.
    if (err) st_mask = '0;
  end

endmodule

// File: rtl/philv_load_store_unit.sv
// Memory-stage LSU: one data-memory access per request, aligned/extended load return.
// Optional BUSY watchdog enabled by defining PHILV_LSU_TIMEOUT_EN.
module philv_load_store_unit
  import philv_load_store_unit_pkg::*;
#(
  parameter int BUS_WIDTH = 32
`ifdef PHILV_LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input logic                 clk,
  input logic                 rst,
  philv_load_store_unit_if.slave bus
);

  lsu_state_e           state, state_nx;
  lsu_req_t             req_q;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d, resp_set;
  logic                 idle, busy, accept, tmo_hit;

  logic                 al_we, al_err;
  logic [2:0]           al_funct3;
  logic [1:0]           al_lane;
  logic [XLEN-1:0]      al_wdata, al_load, al_st_data;
  logic [3:0]           al_st_mask;

  assign idle   = (state == ST_IDLE);
  assign busy   = (state == ST_BUSY);
  assign accept = idle & bus.req_valid;

  // Legality is judged on the live request while idle; afterwards on the captured copy.
  assign al_we     = idle ? bus.req_we        : req_q.we;
  assign al_funct3 = idle ? bus.req_funct3    : req_q.funct3;
  assign al_lane   = idle ? bus.req_addr[1:0] : req_q.addr[1:0];
  assign al_wdata  = idle ? bus.req_wdata     : req_q.wdata;

  philv_load_store_unit_lane_align u_lane_align (
    .we        (al_we),
    .funct3    (al_funct3),
    .lane      (al_lane),
    .rd_word   (bus.mem_rd_data),
    .wdata     (al_wdata),
    .load_data (al_load),
    .st_data   (al_st_data),
    .st_mask   (al_st_mask),
    .err       (al_err)
  );

`ifdef PHILV_LSU_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst)         tmo_cnt <= '0;
    else if (accept) tmo_cnt <= '0;
    else if (busy)   tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = busy && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    resp_set = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (al_err) begin
            state_nx = ST_RESP;
            resp_set = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_nx = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (bus.mem_ack) begin
          state_nx = ST_RESP;
          resp_set = 1'b1;
          rdata_d  = req_q.we ? '0 : al_load;
        end else if (tmo_hit) begin
          state_nx = ST_RESP;
          resp_set = 1'b1;
          err_d    = 1'b1;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_q <= '{we: bus.req_we, funct3: bus.req_funct3,
                   addr: bus.req_addr, wdata: bus.req_wdata};
      end
      if (resp_set) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  assign bus.req_ready   = idle & ~rst;
  assign bus.resp_valid  = (state == ST_RESP) & ~rst;
  assign bus.resp_rdata  = rst ? '0 : rdata_q;
  assign bus.resp_err    = err_q & ~rst;
  assign bus.mem_rd_ena  = busy & ~req_q.we & ~rst;
  assign bus.mem_wr_ena  = busy & req_q.we & ~rst;
  assign bus.mem_addr    = (busy & ~rst) ? {req_q.addr[XLEN-1:2], 2'b00} : '0;
  assign bus.mem_wr_data = (busy & req_q.we & ~rst) ? al_st_data : '0;
  assign bus.mem_wr_mask = (busy & req_q.we & ~rst) ? al_st_mask : '0;

endmodule

// File: tb/tb_philv_load_store_unit.sv
// Randomized bench for the load/store unit against an arithmetic reference model.
module tb_philv_load_store_unit;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  philv_load_store_unit_if bus ();

`ifdef PHILV_LSU_TIMEOUT_EN
  philv_load_store_unit #(.BUS_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  philv_load_store_unit #(.BUS_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int access_bytes(input int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit model_err(input bit we, input int f3, input logic [31:0] addr);
    if (we && f3 > 2) return 1'b1;
    if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    return (addr % access_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input int f3, input logic [31:0] addr, input logic [31:0] word);
    longint w, v;
    int sh;
    w = longint'(word);
    sh = 8 * int'(addr % 4);
    v = 0;
    case (f3)
      0: begin v = (w >> sh) & 255;   if (v >= 128)   v = v - 256;   end
      1: begin v = (w >> sh) & 65535; if (v >= 32768) v = v - 65536; end
      2: v = w;
      4: v = (w >> sh) & 255;
      5: v = (w >> sh) & 65535;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_mask(input int f3, input logic [31:0] addr);
    longint m;
    m = ((longint'(1) << access_bytes(f3)) - 1) << int'(addr % 4);
    return m[31:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] wd);
    longint v;
    case (f3)
      0: v = (longint'(wd) & 255) * 64'h0101_0101;
      1: v = (longint'(wd) & 65535) * 64'h0001_0001;
      default: v = longint'(wd);
    endcase
    return v[31:0];
  endfunction

  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word, input int k);
    bit          e, tmo;
    int          busy_n;
    logic [31:0] exp_rd;
    e      = model_err(we, int'(f3), addr);
    tmo    = 1'b0;
    busy_n = k;
`ifdef PHILV_LSU_TIMEOUT_EN
    if (k > TMO) begin busy_n = TMO; tmo = 1'b1; end
`endif
    @(negedge clk);
    check("idle_ready", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    if (!e) begin
      for (int i = 1; i <= busy_n; i++) begin
        check("busy_rd_ena", bus.mem_rd_ena, !we);
        check("busy_wr_ena", bus.mem_wr_ena, we);
        check("busy_addr", bus.mem_addr, addr - (addr % 4));
        check("busy_ready", bus.req_ready, 0);
        check("busy_resp", bus.resp_valid, 0);
        if (we) begin
          check("wr_mask", bus.mem_wr_mask, model_mask(int'(f3), addr));
          check("wr_data", bus.mem_wr_data, model_wdata(int'(f3), wdata));
        end
        if (i == k) begin
          bus.mem_ack     = 1'b1;
          bus.mem_rd_data = word;
        end
        @(negedge clk);
        bus.mem_ack     = 1'b0;
        bus.mem_rd_data = $urandom;
      end
    end
    exp_rd = (e || tmo || we) ? 32'd0 : model_load(int'(f3), addr, word);
    check("resp_valid", bus.resp_valid, 1);
    check("resp_err", bus.resp_err, e || tmo);
    check("resp_rdata", bus.resp_rdata, exp_rd);
    check("resp_rd_ena", bus.mem_rd_ena, 0);
    check("resp_wr_ena", bus.mem_wr_ena, 0);
    // A stray ack while not busy must be ignored.
    bus.mem_ack = 1'($urandom);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("post_valid", bus.resp_valid, 0);
    check("post_ready", bus.req_ready, 1);
    check("post_hold", bus.resp_rdata, exp_rd);
    check("post_rd_ena", bus.mem_rd_ena, 0);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_funct3  = 3'd0;
    bus.req_addr    = 32'd0;
    bus.req_wdata   = 32'd0;
    bus.mem_rd_data = 32'd0;
    bus.mem_ack     = 1'b0;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.req_ready, 0);
    check("rst_valid", bus.resp_valid, 0);
    check("rst_rd_ena", bus.mem_rd_ena, 0);
    check("rst_wr_ena", bus.mem_wr_ena, 0);
    rst = 1'b0;
    #1;
    check("rst_exit_ready", bus.req_ready, 1);

    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 1);
    run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 3);
    run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_FF7F, 2);
    run_txn(1'b1, 3'b001, 32'h206, 32'h1234_ABCD, 32'h0, 2);
    run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
    run_txn(1'b1, 3'b000, 32'h209, 32'h0000_005A, 32'h0, 1);
    run_txn(1'b1, 3'b011, 32'h200, 32'h1, 32'h0, 1);

    // Reset while a load is outstanding, then a late ack.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h400;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    check("rstb_rd_ena", bus.mem_rd_ena, 1);
    rst = 1'b1;
    #1;
    check("rstb_in_rd_ena", bus.mem_rd_ena, 0);
    check("rstb_in_ready", bus.req_ready, 0);
    @(negedge clk);
    rst             = 1'b0;
    bus.mem_ack     = 1'b1;
    bus.mem_rd_data = 32'h5555_AAAA;
    #1;
    check("rstb_out_rd_ena", bus.mem_rd_ena, 0);
    check("rstb_out_ready", bus.req_ready, 1);
    check("rstb_out_valid", bus.resp_valid, 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("rstb_late_valid", bus.resp_valid, 0);
    check("rstb_late_rd_ena", bus.mem_rd_ena, 0);

`ifdef PHILV_LSU_TIMEOUT_EN
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h1234_5678, 20);
`endif

    for (int n = 0; n < 200; n++) begin
      bit          r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      r_we   = 1'($urandom);
      r_f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (r_we ? 3'($urandom_range(0, 2))
                                                                   : 3'($urandom_range(0, 5)));
      r_addr = 32'h1000 + 32'($urandom_range(0, 255));
      run_txn(r_we, r_f3, r_addr, $urandom, $urandom, $urandom_range(1, 6));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
